// File: rtl/bch_dec_enc_ser_if.sv
// Handshake bundle for the serial DEC BCH encoder: data input channel,
// codeword output channel and the busy indication.
`timescale 1ns/1ps
interface bch_dec_enc_ser_if #(
    parameter int P_D_WIDTH = 16
);
    // Field size m: smallest m in 5..8 whose full code length fits the data plus 2m check bits.
    localparam int LP_M     = (P_D_WIDTH + 10 <= 31)  ? 5 :
                              (P_D_WIDTH + 12 <= 63)  ? 6 :
                              (P_D_WIDTH + 14 <= 127) ? 7 : 8;
    localparam int LP_ECC_W = 2 * LP_M;

    logic [P_D_WIDTH-1:0]          data_i;
    logic                          data_vld_i;
    logic                          data_rdy_o;
    logic [P_D_WIDTH+LP_ECC_W-1:0] cw_o;
    logic                          cw_vld_o;
    logic                          cw_rdy_i;
    logic                          busy_o;

    modport master (
        output data_i, data_vld_i, cw_rdy_i,
        input  data_rdy_o, cw_o, cw_vld_o, busy_o
    );

    modport slave (
        input  data_i, data_vld_i, cw_rdy_i,
        output data_rdy_o, cw_o, cw_vld_o, busy_o
    );
endinterface

// File: rtl/bch_dec_enc_ser.sv
// Serial systematic encoder for the shortened double-error-correcting BCH code.
// A data word is divided MSB-first by g(x) = m1(x)*m3(x) in an LFSR, one bit per
// clock; the data register rotates in step so it holds the original word again
// when the remainder is complete, and {data, check} is then offered downstream.
`timescale 1ns/1ps
module bch_dec_enc_ser #(
    parameter int P_D_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bch_dec_enc_ser_if.slave   bus
);
    localparam int LP_M     = (P_D_WIDTH + 10 <= 31)  ? 5 :
                              (P_D_WIDTH + 12 <= 63)  ? 6 :
                              (P_D_WIDTH + 14 <= 127) ? 7 : 8;
    localparam int LP_ECC_W = 2 * LP_M;
    localparam int LP_CNT_W = $clog2(P_D_WIDTH + 1);

    // Generator polynomials including the x^(2m) term; only the low 2m bits feed the LFSR.
    localparam logic [16:0] LP_G = (LP_M == 5) ? 17'h00769 :
                                   (LP_M == 6) ? 17'h01539 :
                                   (LP_M == 7) ? 17'h04377 : 17'h16F63;
    localparam logic [LP_ECC_W-1:0] LP_G_LOW = LP_G[LP_ECC_W-1:0];
    localparam logic [LP_CNT_W-1:0] LP_LAST  = LP_CNT_W'(P_D_WIDTH - 1);

    generate
        if (P_D_WIDTH < 1 || P_D_WIDTH > 239) begin : g_bad_width
            $error("bch_dec_enc_ser: P_D_WIDTH must be in 1..239");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [P_D_WIDTH-1:0]   sreg;
    logic [LP_ECC_W-1:0]    lfsr;
    logic [LP_CNT_W-1:0]    cnt;
    logic                   fb;

    // Rotate left by one; width 1 degenerates to identity.
    function automatic logic [P_D_WIDTH-1:0] rotl1(input logic [P_D_WIDTH-1:0] v);
        return (v << 1) | (v >> (P_D_WIDTH - 1));
    endfunction

    assign fb = sreg[P_D_WIDTH-1] ^ lfsr[LP_ECC_W-1];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, count out the shifts, wait for downstream.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.data_vld_i)  state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == LP_LAST)  state_nxt = S_OUT;
            S_OUT:   if (bus.cw_rdy_i)    state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load the word, then one division step and one rotation per SHIFT cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg <= '0;
            lfsr <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.data_vld_i) begin
                        sreg <= bus.data_i;
                        lfsr <= '0;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    lfsr <= {lfsr[LP_ECC_W-2:0], 1'b0} ^ (fb ? LP_G_LOW : '0);
                    sreg <= rotl1(sreg);
                    cnt  <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come from state and registers only, so cw_o is frozen while OUT waits.
    assign bus.data_rdy_o = (state == S_IDLE);
    assign bus.cw_vld_o   = (state == S_OUT);
    assign bus.busy_o     = (state != S_IDLE);
    assign bus.cw_o       = {sreg, lfsr};

endmodule
